// File: rtl/xbar_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xbar_pkg
// Purpose  : Shared types and constants for the memory bus crossbar:
//            ownership FSM states, owner encoding, and read-pipe entry width.
// Revision : 1.0 - initial release
// ============================================================================
package xbar_pkg;

  // Bus ownership phases
  typedef enum logic [1:0] {
    ST_RETURN  = 2'd0,
    ST_CPU_OWN = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DBG_OWN = 2'd3
  } xbar_state_t;

  // Which master a read-return entry belongs to
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  // Read-return entry is {valid, slave index, owner}
  function automatic int pipe_entry_w(input int sel_w);
    return 1 + sel_w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_xbar_rd_return_pipe.sv
`default_nettype none
// ============================================================================
// Module   : rd_return_pipe
// Purpose  : RD_LAT-deep delay line carrying {valid, idx, owner} so read data
//            is steered to the master that issued it, even after ownership
//            has moved on.
// Revision : 1.0 - initial release
// ============================================================================
module rd_return_pipe #(
  parameter int ENTRY_W = 4,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ENTRY_W-1:0] in_entry,
  output logic [ENTRY_W-1:0] out_entry
);

  logic [ENTRY_W-1:0] r_stage [RD_LAT];

  // Shift one entry per cycle; reset flushes every in-flight read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= in_entry;
      for (int i = 1; i < RD_LAT; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign out_entry = r_stage[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/mem_bus_xbar.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_xbar
// Purpose  : Two-master (CPU m0, debug m1) byte bus arbiter with address
//            decode to NSLV one-hot slave enables and pipelined read return.
//            Optional MMIO_ERR_EN macro adds unmapped-access error capture
//            (err_clr / err_flag / err_addr).
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_xbar
  import xbar_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 8,
  parameter int NSLV    = 4,
  parameter int SEL_LSB = 16,
  parameter int SEL_W   = 2,
  parameter int RD_LAT  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef MMIO_ERR_EN
  input  logic                   err_clr,
  output logic                   err_flag,
  output logic [ADDR_W-1:0]      err_addr,
`endif
  input  logic [ADDR_W-1:0]      m0_a,
  input  logic                   m0_wr,
  input  logic [DATA_W-1:0]      m0_dout,
  output logic [DATA_W-1:0]      m0_din,
  output logic                   m0_rdy,
  input  logic                   m1_req,
  output logic                   m1_gnt,
  input  logic [ADDR_W-1:0]      m1_a,
  input  logic                   m1_wr,
  input  logic [DATA_W-1:0]      m1_dout,
  output logic [DATA_W-1:0]      m1_din,
  output logic [NSLV-1:0]        s_en,
  output logic [ADDR_W-1:0]      s_a,
  output logic                   s_wr,
  output logic [DATA_W-1:0]      s_dout,
  input  logic [NSLV*DATA_W-1:0] s_din
);

  localparam int              C_ENTRY_W = pipe_entry_w(SEL_W);
  localparam logic [2:0]      C_LAT     = 3'(RD_LAT);
  localparam logic [2:0]      C_LAT_M1  = 3'(RD_LAT - 1);
  localparam logic [SEL_W:0]  C_NSLV    = (SEL_W+1)'(NSLV);

  xbar_state_t          r_state, w_state_nxt;
  logic [2:0]           r_cnt, w_cnt_nxt;
  logic                 w_owning, w_owner;
  logic [ADDR_W-1:0]    w_own_a;
  logic                 w_own_wr;
  logic [DATA_W-1:0]    w_own_dout;
  logic [SEL_W-1:0]     w_idx;
  logic                 w_mapped;
  logic [C_ENTRY_W-1:0] w_push, w_pop;
  logic                 w_pop_valid, w_pop_owner;
  logic [SEL_W-1:0]     w_pop_idx;
  logic [DATA_W-1:0]    w_rd_data;
  logic [DATA_W-1:0]    r_m0_din, r_m1_din;

  // Ownership state and phase counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RETURN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, phase counting and ownership outputs; RETURN spans RD_LAT+1
  // cycles so slave reads of the previous owner have settled
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    m0_rdy      = 1'b0;
    m1_gnt      = 1'b0;
    w_owning    = 1'b0;
    w_owner     = OWN_CPU;
    unique case (r_state)
      ST_RETURN: begin
        if (r_cnt == C_LAT) begin
          w_cnt_nxt   = '0;
          w_state_nxt = m1_req ? ST_DRAIN : ST_CPU_OWN;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      ST_CPU_OWN: begin
        m0_rdy   = 1'b1;
        w_owning = 1'b1;
        if (m1_req) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = '0;
        end
      end
      ST_DRAIN: begin
        if (r_cnt == C_LAT_M1) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_DBG_OWN;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      ST_DBG_OWN: begin
        m1_gnt   = 1'b1;
        w_owning = 1'b1;
        w_owner  = OWN_DBG;
        if (!m1_req) begin
          w_state_nxt = ST_RETURN;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_RETURN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_own_a    = (w_owner == OWN_DBG) ? m1_a    : m0_a;
  assign w_own_wr   = (w_owner == OWN_DBG) ? m1_wr   : m0_wr;
  assign w_own_dout = (w_owner == OWN_DBG) ? m1_dout : m0_dout;
  assign w_idx      = w_own_a[SEL_LSB +: SEL_W];
  assign w_mapped   = {1'b0, w_idx} < C_NSLV;

  // Slave bus is quiet (all zero) whenever nobody owns it
  assign s_a    = w_owning ? w_own_a    : '0;
  assign s_dout = w_owning ? w_own_dout : '0;
  assign s_wr   = w_owning & w_own_wr & w_mapped;

  // One-hot decode; indices at or above NSLV never match
  always_comb begin
    s_en = '0;
    for (int i = 0; i < NSLV; i++) s_en[i] = w_owning && (w_idx == SEL_W'(i));
  end

  assign w_push = {w_owning & ~w_own_wr, w_idx, w_owner};

  rd_return_pipe #(
    .ENTRY_W (C_ENTRY_W),
    .RD_LAT  (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_entry  (w_push),
    .out_entry (w_pop)
  );

  assign w_pop_valid = w_pop[C_ENTRY_W-1];
  assign w_pop_idx   = w_pop[1 +: SEL_W];
  assign w_pop_owner = w_pop[0];

  // Select the returning slave's data; unmapped index yields zero
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NSLV; i++)
      if (w_pop_idx == SEL_W'(i)) w_rd_data = s_din[i*DATA_W +: DATA_W];
  end

  assign m0_din = (w_pop_valid && w_pop_owner == OWN_CPU) ? w_rd_data : r_m0_din;
  assign m1_din = (w_pop_valid && w_pop_owner == OWN_DBG) ? w_rd_data : r_m1_din;

  // Hold last delivered read data for each master
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m0_din <= '0;
      r_m1_din <= '0;
    end else begin
      r_m0_din <= m0_din;
      r_m1_din <= m1_din;
    end
  end

`ifdef MMIO_ERR_EN
  logic              w_unmapped;
  logic              r_err_flag;
  logic [ADDR_W-1:0] r_err_addr;

  assign w_unmapped = w_owning & ~w_mapped;

  // Capture first unmapped access; a coincident clear lets a new one win
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_flag <= 1'b0;
      r_err_addr <= '0;
    end else if (w_unmapped && (!r_err_flag || err_clr)) begin
      r_err_flag <= 1'b1;
      r_err_addr <= w_own_a;
    end else if (err_clr) begin
      r_err_flag <= 1'b0;
    end
  end

  assign err_flag = r_err_flag;
  assign err_addr = r_err_addr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_xbar.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_xbar
// Purpose  : Self-checking bench for mem_bus_xbar. Two instances share one
//            stimulus stream: A (NSLV=4, RD_LAT=1) and B (NSLV=3, RD_LAT=3).
//            Optional MMIO_ERR_EN macro enables error-capture checking.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_bus_xbar;

  localparam int M_RET = 0, M_CPU = 1, M_DRN = 2, M_DBG = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] m0_a = '0, m1_a = '0;
  logic        m0_wr = 1'b0, m1_wr = 1'b0, m1_req = 1'b0;
  logic [7:0]  m0_dout = '0, m1_dout = '0;
  logic [31:0] s_din = '0;

  logic [7:0]  a_m0_din, a_m1_din, b_m0_din, b_m1_din;
  logic        a_m0_rdy, a_m1_gnt, b_m0_rdy, b_m1_gnt;
  logic [3:0]  a_s_en;
  logic [2:0]  b_s_en;
  logic [31:0] a_s_a, b_s_a;
  logic        a_s_wr, b_s_wr;
  logic [7:0]  a_s_dout, b_s_dout;
`ifdef MMIO_ERR_EN
  logic        err_clr = 1'b0;
  logic        a_err_flag, b_err_flag;
  logic [31:0] a_err_addr, b_err_addr;
  logic        e_err_flag [2];
  logic [31:0] e_err_addr [2];
`endif

  always #5 clk = ~clk;

  mem_bus_xbar #(.NSLV(4), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
`ifdef MMIO_ERR_EN
    .err_clr(err_clr), .err_flag(a_err_flag), .err_addr(a_err_addr),
`endif
    .m0_a(m0_a), .m0_wr(m0_wr), .m0_dout(m0_dout), .m0_din(a_m0_din), .m0_rdy(a_m0_rdy),
    .m1_req(m1_req), .m1_gnt(a_m1_gnt), .m1_a(m1_a), .m1_wr(m1_wr), .m1_dout(m1_dout),
    .m1_din(a_m1_din), .s_en(a_s_en), .s_a(a_s_a), .s_wr(a_s_wr), .s_dout(a_s_dout),
    .s_din(s_din)
  );

  mem_bus_xbar #(.NSLV(3), .RD_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
`ifdef MMIO_ERR_EN
    .err_clr(err_clr), .err_flag(b_err_flag), .err_addr(b_err_addr),
`endif
    .m0_a(m0_a), .m0_wr(m0_wr), .m0_dout(m0_dout), .m0_din(b_m0_din), .m0_rdy(b_m0_rdy),
    .m1_req(m1_req), .m1_gnt(b_m1_gnt), .m1_a(m1_a), .m1_wr(m1_wr), .m1_dout(m1_dout),
    .m1_din(b_m1_din), .s_en(b_s_en), .s_a(b_s_a), .s_wr(b_s_wr), .s_dout(b_s_dout),
    .s_din(s_din[23:0])
  );

  // ---------------- reference model ----------------
  typedef struct { int due; int k; bit dbg; int idx; } rd_t;
  rd_t  pend[$];
  int   mode [2];
  int   tmr  [2];
  logic [7:0] e_m0_din [2];
  logic [7:0] e_m1_din [2];
  int   c_nslv [2] = '{4, 3};
  int   c_lat  [2] = '{1, 3};
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    for (int k = 0; k < 2; k++) begin
      mode[k] = M_RET; tmr[k] = 0; e_m0_din[k] = '0; e_m1_din[k] = '0;
`ifdef MMIO_ERR_EN
      e_err_flag[k] = 1'b0; e_err_addr[k] = '0;
`endif
    end
  endtask

  function automatic logic [7:0] slave_data(input int k, input int idx);
    logic [31:0] v;
    v = s_din;
    return (idx < c_nslv[k]) ? v[idx*8 +: 8] : 8'h00;
  endfunction

  // Deliver reads whose RD_LAT has elapsed to the master that issued them
  task automatic resolve_due();
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].due == cyc) begin
        if (pend[i].dbg) e_m1_din[pend[i].k] = slave_data(pend[i].k, pend[i].idx);
        else             e_m0_din[pend[i].k] = slave_data(pend[i].k, pend[i].idx);
        pend.delete(i);
      end
    end
  endtask

  task automatic check_inst(input int k);
    bit dbg, own, mapped;
    logic [31:0] a;
    logic wr;
    logic [7:0] d;
    int idx;
    string p;
    p      = (k == 0) ? "A." : "B.";
    dbg    = (mode[k] == M_DBG);
    own    = (mode[k] == M_CPU) || dbg;
    a      = dbg ? m1_a : m0_a;
    wr     = dbg ? m1_wr : m0_wr;
    d      = dbg ? m1_dout : m0_dout;
    idx    = int'(a[17:16]);
    mapped = idx < c_nslv[k];
    check({p, "m0_rdy"}, (k == 0) ? a_m0_rdy : b_m0_rdy, mode[k] == M_CPU);
    check({p, "m1_gnt"}, (k == 0) ? a_m1_gnt : b_m1_gnt, dbg);
    check({p, "s_en"},   (k == 0) ? a_s_en   : {1'b0, b_s_en}, (own && mapped) ? (64'd1 << idx) : 64'd0);
    check({p, "s_a"},    (k == 0) ? a_s_a    : b_s_a,    own ? a : 32'd0);
    check({p, "s_wr"},   (k == 0) ? a_s_wr   : b_s_wr,   own && wr && mapped);
    check({p, "s_dout"}, (k == 0) ? a_s_dout : b_s_dout, own ? d : 8'd0);
    check({p, "m0_din"}, (k == 0) ? a_m0_din : b_m0_din, e_m0_din[k]);
    check({p, "m1_din"}, (k == 0) ? a_m1_din : b_m1_din, e_m1_din[k]);
`ifdef MMIO_ERR_EN
    check({p, "err_flag"}, (k == 0) ? a_err_flag : b_err_flag, e_err_flag[k]);
    check({p, "err_addr"}, (k == 0) ? a_err_addr : b_err_addr, e_err_addr[k]);
`endif
  endtask

  task automatic model_update(input int k);
    bit dbg, own;
    logic [31:0] a;
    logic wr;
    int idx;
    dbg = (mode[k] == M_DBG);
    own = (mode[k] == M_CPU) || dbg;
    a   = dbg ? m1_a : m0_a;
    wr  = dbg ? m1_wr : m0_wr;
    idx = int'(a[17:16]);
    if (own && !wr) pend.push_back('{cyc + c_lat[k], k, dbg, idx});
`ifdef MMIO_ERR_EN
    if (own && idx >= c_nslv[k] && (!e_err_flag[k] || err_clr)) begin
      e_err_flag[k] = 1'b1; e_err_addr[k] = a;
    end else if (err_clr) begin
      e_err_flag[k] = 1'b0;
    end
`endif
    case (mode[k])
      M_RET: begin
        tmr[k]++;
        if (tmr[k] == c_lat[k] + 1) begin tmr[k] = 0; mode[k] = m1_req ? M_DRN : M_CPU; end
      end
      M_CPU: if (m1_req) begin tmr[k] = 0; mode[k] = M_DRN; end
      M_DRN: begin
        tmr[k]++;
        if (tmr[k] == c_lat[k]) begin tmr[k] = 0; mode[k] = M_DBG; end
      end
      default: if (!m1_req) begin tmr[k] = 0; mode[k] = M_RET; end
    endcase
  endtask

  // One bus cycle: inputs already driven at posedge+1, check at negedge
  task automatic step();
    #4;
    if (!rst_n) model_reset();
    resolve_due();
    for (int k = 0; k < 2; k++) check_inst(k);
    if (rst_n) for (int k = 0; k < 2; k++) model_update(k);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    m0_a    = $urandom;
    m0_wr   = 1'($urandom % 2);
    m0_dout = 8'($urandom);
    m1_a    = $urandom;
    m1_wr   = 1'($urandom % 2);
    m1_dout = 8'($urandom);
    s_din   = $urandom;
    if ($urandom % 6 == 0) m1_req = ~m1_req;
`ifdef MMIO_ERR_EN
    err_clr = ($urandom % 8 == 0);
`endif
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset held: every output must be zero
    for (int i = 0; i < 3; i++) begin drive_rand(); m1_req = 1'b0; step(); end

    // Release; CPU reads slave 1 continuously, slave 1 returns 0xA5
    rst_n = 1'b1; m1_req = 1'b0; m0_wr = 1'b0; m0_a = 32'h0001_0004; s_din = 32'h0000_A500;
    m1_wr = 1'b0;
`ifdef MMIO_ERR_EN
    err_clr = 1'b0;
`endif
    for (int i = 0; i < 4; i++) step();

    // CPU read in the same cycle debug requests; data lands during DRAIN
    m0_a = 32'h0002_0008; s_din = 32'h00C3_0000; m1_req = 1'b1;
    step();
    m0_a = 32'h0000_0000; m1_a = 32'h0000_0010; m1_wr = 1'b1; m1_dout = 8'h5A;
    for (int i = 0; i < 3; i++) step();
    m1_req = 1'b0; m1_wr = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Unmapped slave 3 on B, then clear, then clear coinciding with new error
    m0_a = 32'h0003_0000;
    for (int i = 0; i < 8; i++) step();
`ifdef MMIO_ERR_EN
    m0_a = 32'h0000_0000; err_clr = 1'b1; step();
    err_clr = 1'b0; step();
    m0_a = 32'h0003_0044; step();
    m0_a = 32'h0003_0088; err_clr = 1'b1; step();
    err_clr = 1'b0;
`endif

    // Back-to-back reads to slaves 0,1,2 with changing data
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) begin
        m0_a = 32'(i) << 16; s_din = $urandom; step();
      end
    end
    for (int i = 0; i < 4; i++) begin s_din = $urandom; step(); end

    // Randomised traffic with a mid-run reset
    for (int n = 0; n < 3000; n++) begin
      drive_rand();
      rst_n = !(n >= 1500 && n < 1502);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
